abl_seq: RTL and testbench

//  Parametrised address-bus-low generator for the microcoded 65C02 datapath: base select + add,

---
 rtl/abl_seq_pkg.sv | 23 ++
 rtl/abl_hold_stack.sv | 70 +++++++
 rtl/abl_seq.sv | 118 +++++++++++
 tb/tb_abl_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/abl_seq_pkg.sv
// Shared definitions for the address-bus-low sequencer: op field positions,
// base/offset select encodings and the fixup FSM state type.
package abl_pkg;
  localparam int OP_INV  = 4;  // invert branch condition
  localparam int OP_BASE = 2;  // lsb of the 2-bit base select
  localparam int OP_OFS  = 0;  // lsb of the 2-bit offset select

  typedef enum logic [1:0] {
    BASE_ZERO = 2'b00,
    BASE_DB   = 2'b01,
    BASE_AHL  = 2'b10,
    BASE_BR   = 2'b11   // DB when the branch is taken, else 0
  } base_sel_t;

  typedef enum logic [1:0] {
    OFS_REG  = 2'b00,   // REG + CI, base ignored
    OFS_BREG = 2'b01,   // base + REG + CI
    OFS_BPCL = 2'b10,   // base + PCL + CI
    OFS_BABL = 2'b11    // base + ABL + CI
  } ofs_sel_t;

  typedef enum logic {RUN = 1'b0, FIX = 1'b1} state_t;
endpackage

// File: rtl/abl_hold_stack.sv
// Address-hold LIFO. Push writes din above the current top, pop discards the
// top, push+pop overwrites the top (acts as a push when empty). Overflow and
// underflow are dropped and latch a sticky error until reset.
// Ports: clk, rst_n, push, pop, din[W] -> top[W] (0 when empty), full, empty, err.
module abl_hold_stack
  import abl_pkg::*;
#(
  parameter int W          = 8,
  parameter int HOLD_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         err
);
  localparam int CW = $clog2(HOLD_DEPTH + 1);

  logic [HOLD_DEPTH-1:0][W-1:0] mem;
  logic [CW-1:0]                count, cnt_nxt, wr_idx;
  logic                         wr_en, err_set;

  assign full  = (count == CW'(HOLD_DEPTH));
  assign empty = (count == '0);

  // Entry i is the top when count == i+1.
  always_comb begin
    top = '0;
    for (int i = 0; i < HOLD_DEPTH; i++)
      if (count == CW'(i + 1)) top = mem[i];
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = count;
    cnt_nxt = count;
    err_set = 1'b0;
    if (push && pop) begin
      wr_en = 1'b1;
      if (empty) cnt_nxt = CW'(1);
      else       wr_idx  = count - CW'(1);
    end else if (push) begin
      if (full) err_set = 1'b1;
      else begin
        wr_en   = 1'b1;
        cnt_nxt = count + CW'(1);
      end
    end else if (pop) begin
      if (empty) err_set = 1'b1;
      else       cnt_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= cnt_nxt;
      if (err_set) err <= 1'b1;
      for (int i = 0; i < HOLD_DEPTH; i++)
        if (wr_en && wr_idx == CW'(i)) mem[i] <= din;
    end
  end
endmodule

// File: rtl/abl_seq.sv
// Address-bus-low generator: base/offset adder, registered ABL, PCL update,
// hold LIFO and a one-cycle page-cross fixup FSM that freezes the low half and
// hands the carry to ABH through fix_co.
// Ports: clk, rst_n, CI, cond, DB[W], REG[W], op[5], fix_en, push_ah, pop_ah,
//        ld_pc, inc_pc -> ADL[W], CO, ABL[W], AHL[W], PCL[W], pcl_co, stall,
//        fix_co, ah_full, ah_empty, ah_err.
module abl_seq
  import abl_pkg::*;
#(
  parameter int W          = 8,
  parameter int HOLD_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         CI,
  input  logic         cond,
  input  logic [W-1:0] DB,
  input  logic [W-1:0] REG,
  input  logic [4:0]   op,
  input  logic         fix_en,
  input  logic         push_ah,
  input  logic         pop_ah,
  input  logic         ld_pc,
  input  logic         inc_pc,
  output logic [W-1:0] ADL,
  output logic         CO,
  output logic [W-1:0] ABL,
  output logic [W-1:0] AHL,
  output logic [W-1:0] PCL,
  output logic         pcl_co,
  output logic         stall,
  output logic         fix_co,
  output logic         ah_full,
  output logic         ah_empty,
  output logic         ah_err
);
  state_t    state;
  base_sel_t bsel;
  ofs_sel_t  osel;
  logic          branch, run;
  logic [W-1:0]  base;
  logic [W:0]    sum, pcl_sum;

  assign run    = (state == RUN);
  assign branch = cond ^ op[OP_INV];
  assign bsel   = base_sel_t'(op[OP_BASE +: 2]);
  assign osel   = ofs_sel_t'(op[OP_OFS +: 2]);

  always_comb begin
    base = '0;
    case (bsel)
      BASE_ZERO: base = '0;
      BASE_DB:   base = DB;
      BASE_AHL:  base = AHL;
      BASE_BR:   base = branch ? DB : '0;
      default:   base = '0;
    endcase
  end

  always_comb begin
    sum = '0;
    case (osel)
      OFS_REG:  sum = (W+1)'(REG) + (W+1)'(CI);
      OFS_BREG: sum = (W+1)'(base) + (W+1)'(REG) + (W+1)'(CI);
      OFS_BPCL: sum = (W+1)'(base) + (W+1)'(PCL) + (W+1)'(CI);
      OFS_BABL: sum = (W+1)'(base) + (W+1)'(ABL) + (W+1)'(CI);
      default:  sum = '0;
    endcase
  end

  // During fixup the low half is frozen; the carry already went out via fix_co.
  assign ADL     = run ? sum[W-1:0] : ABL;
  assign CO      = run ? sum[W] : 1'b0;
  assign pcl_sum = (W+1)'(ABL) + (W+1)'(inc_pc);
  assign pcl_co  = pcl_sum[W];
  assign fix_co  = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      stall <= 1'b0;
      ABL   <= '0;
      PCL   <= '0;
    end else begin
      case (state)
        RUN: begin
          ABL <= ADL;
          if (ld_pc) PCL <= pcl_sum[W-1:0];
          if (fix_en && CO) begin
            state <= FIX;
            stall <= 1'b1;
          end
        end
        FIX: begin
          state <= RUN;
          stall <= 1'b0;
        end
        default: begin
          state <= RUN;
          stall <= 1'b0;
        end
      endcase
    end
  end

  // LIFO requests are ignored while the fixup cycle is in progress.
  abl_hold_stack #(.W(W), .HOLD_DEPTH(HOLD_DEPTH)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ah && run),
    .pop   (pop_ah && run),
    .din   (DB),
    .top   (AHL),
    .full  (ah_full),
    .empty (ah_empty),
    .err   (ah_err)
  );
endmodule

// File: tb/tb_abl_seq.sv
module tb_abl_seq;
  localparam int W = 8;
  localparam int D = 2;

  logic clk, rst_n, CI, cond, fix_en, push_ah, pop_ah, ld_pc, inc_pc;
  logic [W-1:0] DB, REG;
  logic [4:0]   op;
  logic [W-1:0] ADL, ABL, AHL, PCL;
  logic CO, pcl_co, stall, fix_co, ah_full, ah_empty, ah_err;

  int n_checks = 0;
  int n_pass   = 0;

  abl_seq #(.W(W), .HOLD_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .CI(CI), .cond(cond), .DB(DB), .REG(REG), .op(op),
    .fix_en(fix_en), .push_ah(push_ah), .pop_ah(pop_ah), .ld_pc(ld_pc), .inc_pc(inc_pc),
    .ADL(ADL), .CO(CO), .ABL(ABL), .AHL(AHL), .PCL(PCL), .pcl_co(pcl_co),
    .stall(stall), .fix_co(fix_co), .ah_full(ah_full), .ah_empty(ah_empty), .ah_err(ah_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    CI = 0; cond = 0; fix_en = 0; push_ah = 0; pop_ah = 0; ld_pc = 0; inc_pc = 0;
    DB = 0; REG = 0; op = 0;
  endtask

  // Load ABL with v: op base=DB, offset=base+REG with REG=0.
  task automatic load_abl(input logic [W-1:0] v);
    idle(); op = 5'b00101; DB = v; step();
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; #12;
    n_checks++;
    if ({ABL, PCL, AHL, ah_empty, ah_full, ah_err, stall, fix_co} !== {8'h00, 8'h00, 8'h00, 5'b10000})
      $display("FAIL reset_state got %h exp %h", {ABL, PCL, AHL, ah_empty, ah_full, ah_err, stall, fix_co},
               {8'h00, 8'h00, 8'h00, 5'b10000});
    else n_pass++;
    rst_n = 1; #1;
    op = 5'b00101; REG = 8'h05; DB = 8'h10; #1;
    n_checks++;
    if (ADL !== 8'h15) $display("FAIL add_db_reg got %h exp 15", ADL); else n_pass++;
    step();
    n_checks++;
    if (ABL !== 8'h15) $display("FAIL abl_reg got %h exp 15", ABL); else n_pass++;
  endtask

  task automatic test_fixup();
    load_abl(8'hF0);
    op = 5'b01111; cond = 1; DB = 8'h20; fix_en = 1; #1;
    n_checks++;
    if ({CO, ADL} !== 9'h110) $display("FAIL fix_carry got %h exp 110", {CO, ADL}); else n_pass++;
    step();
    n_checks++;
    if ({stall, fix_co, ABL, CO, ADL} !== {2'b11, 8'h10, 1'b0, 8'h10})
      $display("FAIL fix_cycle got %h exp %h", {stall, fix_co, ABL, CO, ADL}, {2'b11, 8'h10, 1'b0, 8'h10});
    else n_pass++;
    step();
    n_checks++;
    if (stall !== 1'b0) $display("FAIL fix_exit got %b exp 0", stall); else n_pass++;
    // Inverted condition: not-taken branch gives base 0.
    load_abl(8'hF0);
    op = 5'b11111; cond = 1; DB = 8'h20; fix_en = 1; #1;
    n_checks++;
    if ({CO, ADL} !== 9'h0F0) $display("FAIL branch_inv got %h exp 0f0", {CO, ADL}); else n_pass++;
    step();
    n_checks++;
    if (stall !== 1'b0) $display("FAIL no_stall got %b exp 0", stall); else n_pass++;
  endtask

  task automatic test_pcl();
    load_abl(8'hFF);
    op = 5'b00101; DB = 8'hFF; ld_pc = 1; inc_pc = 1; #1;
    n_checks++;
    if (pcl_co !== 1'b1) $display("FAIL pcl_co got %b exp 1", pcl_co); else n_pass++;
    step();
    n_checks++;
    if (PCL !== 8'h00) $display("FAIL pcl_wrap got %h exp 00", PCL); else n_pass++;
    load_abl(8'hF0);
    op = 5'b01111; cond = 1; DB = 8'h20; fix_en = 1; step();   // now in FIX, ABL=10
    ld_pc = 1; inc_pc = 0; step();
    n_checks++;
    if (PCL !== 8'h00) $display("FAIL pcl_in_fix got %h exp 00", PCL); else n_pass++;
  endtask

  task automatic test_lifo();
    idle(); push_ah = 1; DB = 8'h11; step(); DB = 8'h22; step();
    n_checks++;
    if ({AHL, ah_full} !== 9'h045) $display("FAIL lifo_full got %h exp 045", {AHL, ah_full}); else n_pass++;
    DB = 8'h33; step();
    n_checks++;
    if ({AHL, ah_err} !== 9'h045) $display("FAIL lifo_ovf got %h exp 045", {AHL, ah_err}); else n_pass++;
    pop_ah = 1; DB = 8'h44; step();
    n_checks++;
    if (AHL !== 8'h44) $display("FAIL lifo_ovw got %h exp 44", AHL); else n_pass++;
    push_ah = 0; step();
    n_checks++;
    if (AHL !== 8'h11) $display("FAIL lifo_pop got %h exp 11", AHL); else n_pass++;
    step(); step();
    n_checks++;
    if ({AHL, ah_empty, ah_err} !== 10'h003) $display("FAIL lifo_unf got %h exp 003", {AHL, ah_empty, ah_err});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    idle(); push_ah = 1; DB = 8'hA1; step(); DB = 8'hA2; step();
    load_abl(8'hF0);
    op = 5'b01111; cond = 1; DB = 8'h20; fix_en = 1; step();
    n_checks++;
    if ({stall, ah_full, ah_err} !== 3'b111) $display("FAIL pre_reset got %b exp 111", {stall, ah_full, ah_err});
    else n_pass++;
    #2 rst_n = 0; #1;
    n_checks++;
    if ({stall, ah_empty, ah_err, ABL} !== {3'b010, 8'h00})
      $display("FAIL async_reset got %h exp %h", {stall, ah_empty, ah_err, ABL}, {3'b010, 8'h00});
    else n_pass++;
    idle(); #3 rst_n = 1;
  endtask

  // Reference model state
  int  m_abl, m_pcl;
  bit  m_fix, m_err;
  int  m_q[$];

  task automatic test_random();
    int e_adl, e_co, s, b, base, ahl;
    logic [38:0] obs, exp_v;
    step();
    m_abl = 0; m_pcl = 0; m_fix = 0; m_err = 0; m_q.delete();
    for (int c = 0; c < 400; c++) begin
      CI = 1'($urandom); cond = 1'($urandom); DB = 8'($urandom); REG = 8'($urandom);
      op = 5'($urandom); fix_en = ($urandom_range(0, 2) != 0); push_ah = 1'($urandom);
      pop_ah = 1'($urandom); ld_pc = 1'($urandom); inc_pc = 1'($urandom);
      if (c % 50 == 0) begin REG = 8'hFF; op = 5'b00001; CI = 1; end
      #1;
      ahl = (m_q.size() > 0) ? m_q[$] : 0;
      b = cond ^ op[4];
      case (op[3:2])
        2'd0: base = 0;
        2'd1: base = DB;
        2'd2: base = ahl;
        default: base = b ? DB : 0;
      endcase
      case (op[1:0])
        2'd0: s = REG + CI;
        2'd1: s = base + REG + CI;
        2'd2: s = base + m_pcl + CI;
        default: s = base + m_abl + CI;
      endcase
      if (m_fix) begin e_adl = m_abl; e_co = 0; end
      else begin e_adl = s % 256; e_co = s / 256; end
      exp_v = {8'(e_adl), 1'(e_co), 8'(m_abl), 8'(ahl), 8'(m_pcl), 1'((m_abl + inc_pc) / 256),
               m_fix, m_fix, m_q.size() == D, m_q.size() == 0, m_err};
      obs = {ADL, CO, ABL, AHL, PCL, pcl_co, stall, fix_co, ah_full, ah_empty, ah_err};
      n_checks++;
      if (obs !== exp_v) $display("FAIL random_cycle_%0d got %h exp %h", c, obs, exp_v);
      else n_pass++;
      @(posedge clk);
      if (m_fix) m_fix = 0;
      else begin
        if (ld_pc) m_pcl = (m_abl + inc_pc) % 256;
        m_abl = e_adl;
        if (push_ah && pop_ah) begin
          if (m_q.size() == 0) m_q.push_back(DB); else m_q[$] = DB;
        end else if (push_ah) begin
          if (m_q.size() < D) m_q.push_back(DB); else m_err = 1;
        end else if (pop_ah) begin
          if (m_q.size() > 0) void'(m_q.pop_back()); else m_err = 1;
        end
        if (fix_en && e_co == 1) m_fix = 1;
      end
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_fixup();
    test_pcl();
    test_lifo();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
